// File: rtl/lfsr_pkg.sv
// lfsr_pkg: shared types, limits and the single-step function for lfsr_gen.
//   lfsr_mode_e    : Fibonacci (feedback into LSB) or Galois (taps on MSB shift-out)
//   lfsr_step()    : one LFSR step on a state zero-extended to LFSR_MAX_WIDTH bits
//   lfsr_params_ok : elaboration-time sanity check of WIDTH/STEPS/COUNT_W
package lfsr_pkg;

  localparam int unsigned LFSR_MAX_WIDTH = 64;

  typedef enum logic {
    LFSR_FIBONACCI = 1'b0,
    LFSR_GALOIS    = 1'b1
  } lfsr_mode_e;

  // Bits at or above 'width' are ignored on input and returned as zero, so
  // the same function serves every WIDTH the top can be built with.
  function automatic logic [LFSR_MAX_WIDTH-1:0] lfsr_step(
    input logic [LFSR_MAX_WIDTH-1:0] state,
    input logic [LFSR_MAX_WIDTH-1:0] taps,
    input lfsr_mode_e                mode,
    input int unsigned               width
  );
    logic [LFSR_MAX_WIDTH-1:0] mask;
    logic [LFSR_MAX_WIDTH-1:0] shifted;
    logic                      msb;
    logic                      fb;
    mask    = {LFSR_MAX_WIDTH{1'b1}} >> (LFSR_MAX_WIDTH - width);
    shifted = (state << 1) & mask;
    msb     = |(state & (LFSR_MAX_WIDTH'(1) << (width - 1)));
    fb      = ^(state & taps & mask);
    if (mode == LFSR_GALOIS) begin
      lfsr_step = shifted ^ (msb ? (taps & mask) : '0);
    end else begin
      lfsr_step = shifted | LFSR_MAX_WIDTH'(fb);
    end
  endfunction

  function automatic bit lfsr_params_ok(input int width, input int steps, input int count_w);
    return (width >= 3) && (width <= int'(LFSR_MAX_WIDTH)) &&
           (steps >= 1) && (steps <= width) && (count_w >= 1);
  endfunction

endpackage

// File: rtl/lfsr_period_tracker.sv
// lfsr_period_tracker: counts advances since the last load, flags when an
// advance lands back on the seed, and captures the first such count as the
// period.
//   clk, rst_i, reinit_i : clock, synchronous reset, seed reload (both clear)
//   advance_i            : an advance is applied this cycle
//   next_state_i         : state the register will hold after this advance
//   seed_i               : currently stored seed
//   step_count_o         : saturating advance counter
//   wrap_o               : one-cycle pulse after an advance that returned to seed
//   period_valid_o/len_o : first measured period, in advances
module lfsr_period_tracker #(
  parameter int WIDTH   = 16,
  parameter int COUNT_W = 24
) (
  input  logic               clk,
  input  logic               rst_i,
  input  logic               reinit_i,
  input  logic               advance_i,
  input  logic [WIDTH-1:0]   next_state_i,
  input  logic [WIDTH-1:0]   seed_i,
  output logic [COUNT_W-1:0] step_count_o,
  output logic               wrap_o,
  output logic               period_valid_o,
  output logic [COUNT_W-1:0] period_len_o
);

  logic [COUNT_W-1:0] step_count_q;
  logic [COUNT_W-1:0] step_count_d;
  logic               wrap_q;
  logic               period_valid_q;
  logic [COUNT_W-1:0] period_len_q;
  logic               hit_seed;

  // Saturating increment; the captured period uses the same value so a
  // narrow counter reports all-ones rather than wrapping to zero.
  assign step_count_d = (step_count_q == '1) ? step_count_q : step_count_q + 1'b1;
  assign hit_seed     = (next_state_i == seed_i);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst_i || reinit_i) begin
      step_count_q   <= '0;
      wrap_q         <= 1'b0;
      period_valid_q <= 1'b0;
      period_len_q   <= '0;
    end else begin
      wrap_q <= 1'b0;
      if (advance_i) begin
        step_count_q <= step_count_d;
        if (hit_seed) begin
          wrap_q <= 1'b1;
          if (!period_valid_q) begin
            period_valid_q <= 1'b1;
            period_len_q   <= step_count_d;
          end
        end
      end
    end
  end

  assign step_count_o   = step_count_q;
  assign wrap_o         = wrap_q;
  assign period_valid_o = period_valid_q;
  assign period_len_o   = period_len_q;

endmodule

// File: rtl/lfsr_gen.sv
// lfsr_gen: seedable parametrised LFSR (Fibonacci or Galois), STEPS single
// steps per advance, with lockup flag and period/wrap tracking.
//   clk, rst            : clock, synchronous active-high reset (loads seed)
//   reinit              : reload seed (below rst, above advance)
//   advance             : apply STEPS steps this cycle
//   initial_state, taps : seed and feedback mask (bit i = state bit i)
//   out, out_state      : low STEPS bits / full current state
//   lockup              : state is all-zero
//   wrap, period_valid, period_len : see lfsr_period_tracker
// Optional build macro LFSR_LOCKUP_RECOVER_EN: an advance from the all-zero
// state reloads the seed (or 1 if the seed is zero) instead of stepping.
module lfsr_gen
  import lfsr_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int STEPS   = 1,
  parameter int GALOIS  = 0,
  parameter int COUNT_W = 24
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               reinit,
  input  logic               advance,
  input  logic [WIDTH-1:0]   initial_state,
  input  logic [WIDTH-1:0]   taps,
  output logic [STEPS-1:0]   out,
  output logic [WIDTH-1:0]   out_state,
  output logic               lockup,
  output logic               wrap,
  output logic               period_valid,
  output logic [COUNT_W-1:0] period_len
);

  localparam lfsr_mode_e MODE = (GALOIS != 0) ? LFSR_GALOIS : LFSR_FIBONACCI;
  localparam bit PARAMS_OK = lfsr_params_ok(WIDTH, STEPS, COUNT_W);

  generate
    if (!PARAMS_OK) begin : g_bad_params
      $error("lfsr_gen: need 3 <= WIDTH <= 64, 1 <= STEPS <= WIDTH, COUNT_W >= 1");
    end
  endgenerate

  logic [WIDTH-1:0]          state_q;
  logic [WIDTH-1:0]          state_d;
  logic [WIDTH-1:0]          seed_q;
  logic [WIDTH-1:0]          step_result;
  logic [LFSR_MAX_WIDTH-1:0] chain;
  logic [COUNT_W-1:0]        step_count;
  logic                      unused_chain_bits;

  // STEPS single steps unrolled into one combinational chain.
  // NOTE: the chain variable is reassigned in sequence inside always_comb, so
  // blocking assignments are required here; it is also given a value before
  // any use so no latch can be inferred.
  always_comb begin
    chain = LFSR_MAX_WIDTH'(state_q);
    for (int i = 0; i < STEPS; i++) begin
      chain = lfsr_step(chain, LFSR_MAX_WIDTH'(taps), MODE, WIDTH);
    end
    step_result = chain[WIDTH-1:0];
  end

  // Bits above WIDTH are always zero by construction of lfsr_step.
  assign unused_chain_bits = ^(chain >> WIDTH);

`ifdef LFSR_LOCKUP_RECOVER_EN
  always_comb begin
    state_d = step_result;
    if (state_q == '0) begin
      state_d = (seed_q == '0) ? WIDTH'(1) : seed_q;
    end
  end
`else
  // Without recovery the all-zero state is a fixed point of both modes.
  assign state_d = step_result;
`endif

  always_ff @(posedge clk) begin
    if (rst || reinit) begin
      state_q <= initial_state;
      seed_q  <= initial_state;
    end else if (advance) begin
      state_q <= state_d;
    end
  end

  lfsr_period_tracker #(
    .WIDTH   (WIDTH),
    .COUNT_W (COUNT_W)
  ) u_tracker (
    .clk            (clk),
    .rst_i          (rst),
    .reinit_i       (reinit),
    .advance_i      (advance),
    .next_state_i   (state_d),
    .seed_i         (seed_q),
    .step_count_o   (step_count),
    .wrap_o         (wrap),
    .period_valid_o (period_valid),
    .period_len_o   (period_len)
  );

  assign out       = state_q[STEPS-1:0];
  assign out_state = state_q;
  assign lockup    = (state_q == '0);

endmodule

// File: tb/tb_lfsr_gen.sv
// tb_lfsr_gen: directed checks of lfsr_gen on four 4-bit builds sharing
// control inputs: A (Fibonacci, STEPS=1), B (STEPS=2), G (Galois),
// C (COUNT_W=3). Expected values are hand-derived for taps 4'b1001.
module tb_lfsr_gen;

  logic       clk = 1'b0;
  logic       rst, reinit, advance;
  logic [3:0] taps;
  logic [3:0] seed_a, seed_b, seed_g, seed_c;

  logic [0:0]  out_a, out_g, out_c;
  logic [1:0]  out_b;
  logic [3:0]  st_a, st_b, st_g, st_c;
  logic        lk_a, lk_b, lk_g, lk_c;
  logic        wr_a, wr_b, wr_g, wr_c;
  logic        pv_a, pv_b, pv_g, pv_c;
  logic [23:0] pl_a, pl_b, pl_g;
  logic [2:0]  pl_c;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  lfsr_gen #(.WIDTH(4), .STEPS(1), .GALOIS(0), .COUNT_W(24)) u_a (
    .clk(clk), .rst(rst), .reinit(reinit), .advance(advance),
    .initial_state(seed_a), .taps(taps), .out(out_a), .out_state(st_a),
    .lockup(lk_a), .wrap(wr_a), .period_valid(pv_a), .period_len(pl_a));

  lfsr_gen #(.WIDTH(4), .STEPS(2), .GALOIS(0), .COUNT_W(24)) u_b (
    .clk(clk), .rst(rst), .reinit(reinit), .advance(advance),
    .initial_state(seed_b), .taps(taps), .out(out_b), .out_state(st_b),
    .lockup(lk_b), .wrap(wr_b), .period_valid(pv_b), .period_len(pl_b));

  lfsr_gen #(.WIDTH(4), .STEPS(1), .GALOIS(1), .COUNT_W(24)) u_g (
    .clk(clk), .rst(rst), .reinit(reinit), .advance(advance),
    .initial_state(seed_g), .taps(taps), .out(out_g), .out_state(st_g),
    .lockup(lk_g), .wrap(wr_g), .period_valid(pv_g), .period_len(pl_g));

  lfsr_gen #(.WIDTH(4), .STEPS(1), .GALOIS(0), .COUNT_W(3)) u_c (
    .clk(clk), .rst(rst), .reinit(reinit), .advance(advance),
    .initial_state(seed_c), .taps(taps), .out(out_c), .out_state(st_c),
    .lockup(lk_c), .wrap(wr_c), .period_valid(pv_c), .period_len(pl_c));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the edge; outputs are read at the same point.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [3:0] fib_seq [15];

  initial begin
    fib_seq = '{4'b0011, 4'b0111, 4'b1111, 4'b1110, 4'b1101, 4'b1010, 4'b0101, 4'b1011,
                4'b0110, 4'b1100, 4'b1001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

    rst = 1'b1; reinit = 1'b0; advance = 1'b0; taps = 4'b1001;
    seed_a = 4'b0001; seed_b = 4'b0001; seed_g = 4'b1000; seed_c = 4'b0001;
    tick();
    rst = 1'b0;
    check("rst_state_a", 32'(st_a), 32'h1);
    check("rst_lockup_a", 32'(lk_a), 32'h0);
    check("rst_wrap_a", 32'(wr_a), 32'h0);
    check("rst_pvalid_a", 32'(pv_a), 32'h0);
    check("rst_plen_a", 32'(pl_a), 32'h0);
    check("rst_state_g", 32'(st_g), 32'h8);

    // Hold: no advance, no change.
    tick();
    check("hold_state_a", 32'(st_a), 32'h1);
    check("hold_count_a", 32'(u_a.step_count), 32'h0);

    // Full Fibonacci period on A; the other builds ride along.
    advance = 1'b1;
    for (int i = 0; i < 15; i++) begin
      tick();
      check($sformatf("seq_a[%0d]", i), 32'(st_a), 32'(fib_seq[i]));
      check($sformatf("wrap_a[%0d]", i), 32'(wr_a), (i == 14) ? 32'h1 : 32'h0);
      check($sformatf("pvalid_a[%0d]", i), 32'(pv_a), (i == 14) ? 32'h1 : 32'h0);
      check($sformatf("count_c[%0d]", i), 32'(u_c.step_count), (i < 7) ? 32'(i + 1) : 32'h7);
      if (i == 0) begin
        check("steps2_state_b", 32'(st_b), 32'h7);
        check("steps2_out_b", 32'(out_b), 32'h3);
        check("steps2_count_b", 32'(u_b.step_count), 32'h1);
        check("galois_state_g", 32'(st_g), 32'h9);
        check("out_a", 32'(out_a), 32'h1);
      end
    end
    check("plen_a", 32'(pl_a), 32'd15);
    check("pvalid_c", 32'(pv_c), 32'h1);
    check("plen_c_sat", 32'(pl_c), 32'h7);

    advance = 1'b0;
    tick();
    check("wrap_pulse_end_a", 32'(wr_a), 32'h0);
    check("pvalid_hold_a", 32'(pv_a), 32'h1);

    // Second period: wrap pulses again, period_len unchanged.
    advance = 1'b1;
    for (int i = 0; i < 15; i++) begin
      tick();
      check($sformatf("wrap2_a[%0d]", i), 32'(wr_a), (i == 14) ? 32'h1 : 32'h0);
    end
    check("plen2_a", 32'(pl_a), 32'd15);
    advance = 1'b0;

    // All-zero seed.
    reinit = 1'b1; seed_a = 4'b0000;
    tick();
    reinit = 1'b0;
    check("zero_state_a", 32'(st_a), 32'h0);
    check("zero_lockup_a", 32'(lk_a), 32'h1);
    check("zero_pvalid_a", 32'(pv_a), 32'h0);
    advance = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
`ifdef LFSR_LOCKUP_RECOVER_EN
      check($sformatf("zadv_state_a[%0d]", i), 32'(st_a), 32'(fib_seq[i] == 4'b0011 ? 4'b0001 :
                                                             (i == 1) ? 4'b0011 : 4'b0111));
      check($sformatf("zadv_lockup_a[%0d]", i), 32'(lk_a), 32'h0);
      check($sformatf("zadv_wrap_a[%0d]", i), 32'(wr_a), 32'h0);
`else
      check($sformatf("zadv_state_a[%0d]", i), 32'(st_a), 32'h0);
      check($sformatf("zadv_lockup_a[%0d]", i), 32'(lk_a), 32'h1);
      check($sformatf("zadv_wrap_a[%0d]", i), 32'(wr_a), 32'h1);
`endif
    end

    // reinit wins over advance.
    reinit = 1'b1; seed_a = 4'b0110;
    tick();
    check("reinit_adv_state_a", 32'(st_a), 32'h6);
    check("reinit_adv_count_a", 32'(u_a.step_count), 32'h0);
    check("reinit_adv_pvalid_a", 32'(pv_a), 32'h0);

    // rst together with reinit.
    rst = 1'b1; advance = 1'b0; seed_a = 4'b0101;
    tick();
    rst = 1'b0; reinit = 1'b0;
    check("rst_reinit_state_a", 32'(st_a), 32'h5);
    check("rst_reinit_count_a", 32'(u_a.step_count), 32'h0);
    check("rst_reinit_pvalid_a", 32'(pv_a), 32'h0);
    check("rst_reinit_lockup_a", 32'(lk_a), 32'h0);

    // Seed latched at load: changing the input now must not create a wrap.
    seed_a = 4'b1011; advance = 1'b1;
    tick();
    advance = 1'b0;
    check("seed_latched_state_a", 32'(st_a), 32'hB);
    check("seed_latched_wrap_a", 32'(wr_a), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
